// File: rtl/mem_stage_if.sv
// Data-memory port of the memory-access stage: valid/ready request with
// byte strobes; the stage is the master, the memory model the slave.
interface mem_stage_if;
  logic        DMEM_VALID;
  logic        DMEM_WE;
  logic [31:0] DMEM_ADDR;
  logic [31:0] DMEM_WDATA;
  logic [3:0]  DMEM_WSTRB;
  logic        DMEM_READY;
  logic [31:0] DMEM_RDATA;

  modport master (
    output DMEM_VALID, DMEM_WE, DMEM_ADDR, DMEM_WDATA, DMEM_WSTRB,
    input  DMEM_READY, DMEM_RDATA
  );

  modport slave (
    input  DMEM_VALID, DMEM_WE, DMEM_ADDR, DMEM_WDATA, DMEM_WSTRB,
    output DMEM_READY, DMEM_RDATA
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: byte/half/word loads and stores over a
// valid/ready port with timeout, branch resolution and MEM/WB registers.
module mem_stage #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        VALID_IN,
  input  logic [2:0]  CRT_MEM_IN,
  input  logic [1:0]  CRT_WB_IN,
  input  logic [2:0]  FUNCT3_IN,
  input  logic [31:0] ALU_RESULT_IN,
  input  logic [31:0] DATO_B_IN,
  input  logic [4:0]  INST_IN,
  input  logic        ZERO_IN,
  input  logic [31:0] PC_NEXT_IN,
  output logic        STALL_OUT,
  output logic        PCSRC_OUT,
  output logic [31:0] PC_BRANCH_OUT,
  mem_stage_if.master dmem,
  output logic        VALID_OUT,
  output logic [1:0]  CRT_WB_OUT,
  output logic [31:0] MEM_DATA_OUT,
  output logic [31:0] ALU_RESULT_OUT,
  output logic [4:0]  INST_OUT,
  output logic        MISALIGN_OUT,
  output logic        BUS_ERR_OUT
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACCESS = 1'b1;

  localparam int             CW        = $clog2(TIMEOUT);
  localparam logic [CW-1:0]  LAST_WAIT = CW'(TIMEOUT - 1);

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  logic [0:0]    r_state;
  logic [CW-1:0] r_wait_cnt;

  logic          r_dmem_valid;
  logic          r_dmem_we;
  logic [31:0]   r_dmem_addr;
  logic [31:0]   r_dmem_wdata;
  logic [3:0]    r_dmem_wstrb;

  // Instruction context held for the duration of an access
  logic          r_is_read;
  logic [2:0]    r_funct3;
  logic [1:0]    r_off;
  logic [31:0]   r_alu_lat;
  logic [4:0]    r_inst_lat;
  logic [1:0]    r_wb_lat;

  logic          r_valid_out;
  logic [1:0]    r_crt_wb;
  logic [31:0]   r_mem_data;
  logic [31:0]   r_alu_out;
  logic [4:0]    r_inst_out;
  logic          r_misalign;
  logic          r_bus_err;

  logic          w_is_read;
  logic          w_is_write;
  logic          w_is_mem;
  logic [1:0]    w_off;
  logic [1:0]    w_size;
  logic          w_misalign;
  logic [31:0]   w_wdata;
  logic [3:0]    w_wstrb;
  logic [31:0]   w_lane;
  logic [31:0]   w_load_fmt;

  // MEM_READ wins when both access bits are set
  assign w_is_read  = CRT_MEM_IN[0];
  assign w_is_write = CRT_MEM_IN[1] & ~CRT_MEM_IN[0];
  assign w_is_mem   = w_is_read | w_is_write;
  assign w_off      = ALU_RESULT_IN[1:0];

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_size = SZ_WORD;
    if (w_is_read) begin
      case (FUNCT3_IN)
        3'b000, 3'b100: w_size = SZ_BYTE;
        3'b001, 3'b101: w_size = SZ_HALF;
        default:        w_size = SZ_WORD;
      endcase
    end else begin
      case (FUNCT3_IN)
        3'b000:  w_size = SZ_BYTE;
        3'b001:  w_size = SZ_HALF;
        default: w_size = SZ_WORD;
      endcase
    end
  end

  assign w_misalign = ((w_size == SZ_HALF) & w_off[0]) |
                      ((w_size == SZ_WORD) & (w_off != 2'b00));

  always_comb begin
    w_wdata = '0;
    w_wstrb = '0;
    if (w_is_write) begin
      case (w_size)
        SZ_BYTE: begin
          w_wdata = {4{DATO_B_IN[7:0]}};
          w_wstrb = 4'b0001 << w_off;
        end
        SZ_HALF: begin
          w_wdata = {2{DATO_B_IN[15:0]}};
          w_wstrb = 4'b0011 << w_off;
        end
        default: begin
          w_wdata = DATO_B_IN;
          w_wstrb = 4'b1111;
        end
      endcase
    end
  end

  assign w_lane = dmem.DMEM_RDATA >> {r_off, 3'b000};

  always_comb begin
    case (r_funct3)
      3'b000:  w_load_fmt = {{24{w_lane[7]}}, w_lane[7:0]};
      3'b001:  w_load_fmt = {{16{w_lane[15]}}, w_lane[15:0]};
      3'b100:  w_load_fmt = {24'd0, w_lane[7:0]};
      3'b101:  w_load_fmt = {16'd0, w_lane[15:0]};
      default: w_load_fmt = w_lane;
    endcase
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_wait_cnt   <= '0;
      r_dmem_valid <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= '0;
      r_dmem_wstrb <= '0;
      r_is_read    <= 1'b0;
      r_funct3     <= '0;
      r_off        <= '0;
      r_alu_lat    <= '0;
      r_inst_lat   <= '0;
      r_wb_lat     <= '0;
      r_valid_out  <= 1'b0;
      r_crt_wb     <= '0;
      r_mem_data   <= '0;
      r_alu_out    <= '0;
      r_inst_out   <= '0;
      r_misalign   <= 1'b0;
      r_bus_err    <= 1'b0;
    end else begin
      r_valid_out <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (VALID_IN) begin
            if (!w_is_mem || w_misalign) begin
              r_valid_out <= 1'b1;
              r_crt_wb    <= w_is_mem ? 2'b00 : CRT_WB_IN;
              r_mem_data  <= '0;
              r_alu_out   <= ALU_RESULT_IN;
              r_inst_out  <= INST_IN;
              r_misalign  <= w_is_mem;
              r_bus_err   <= 1'b0;
            end else begin
              r_state      <= S_ACCESS;
              r_wait_cnt   <= '0;
              r_dmem_valid <= 1'b1;
              r_dmem_we    <= w_is_write;
              r_dmem_addr  <= {ALU_RESULT_IN[31:2], 2'b00};
              r_dmem_wdata <= w_wdata;
              r_dmem_wstrb <= w_wstrb;
              r_is_read    <= w_is_read;
              r_funct3     <= FUNCT3_IN;
              r_off        <= w_off;
              r_alu_lat    <= ALU_RESULT_IN;
              r_inst_lat   <= INST_IN;
              r_wb_lat     <= CRT_WB_IN;
            end
          end
        end
        S_ACCESS: begin
          // READY on the final wait edge still completes the access
          if (dmem.DMEM_READY || r_wait_cnt == LAST_WAIT) begin
            r_state      <= S_IDLE;
            r_dmem_valid <= 1'b0;
            r_valid_out  <= 1'b1;
            r_crt_wb     <= dmem.DMEM_READY ? r_wb_lat : 2'b00;
            r_mem_data   <= (dmem.DMEM_READY && r_is_read) ? w_load_fmt : '0;
            r_alu_out    <= r_alu_lat;
            r_inst_out   <= r_inst_lat;
            r_misalign   <= 1'b0;
            r_bus_err    <= ~dmem.DMEM_READY;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign STALL_OUT     = (r_state == S_ACCESS);
  assign PCSRC_OUT     = VALID_IN & CRT_MEM_IN[2] & ZERO_IN & (r_state == S_IDLE);
  assign PC_BRANCH_OUT = PC_NEXT_IN;

  assign dmem.DMEM_VALID = r_dmem_valid;
  assign dmem.DMEM_WE    = r_dmem_we;
  assign dmem.DMEM_ADDR  = r_dmem_addr;
  assign dmem.DMEM_WDATA = r_dmem_wdata;
  assign dmem.DMEM_WSTRB = r_dmem_wstrb;

  assign VALID_OUT      = r_valid_out;
  assign CRT_WB_OUT     = r_crt_wb;
  assign MEM_DATA_OUT   = r_mem_data;
  assign ALU_RESULT_OUT = r_alu_out;
  assign INST_OUT       = r_inst_out;
  assign MISALIGN_OUT   = r_misalign;
  assign BUS_ERR_OUT    = r_bus_err;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: hand-computed vectors for ALU pass-through,
// loads/stores of every size, misalignment, timeout, branch and reset.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic [2:0]  crt_mem_in;
  logic [1:0]  crt_wb_in;
  logic [2:0]  funct3_in;
  logic [31:0] alu_result_in;
  logic [31:0] dato_b_in;
  logic [4:0]  inst_in;
  logic        zero_in;
  logic [31:0] pc_next_in;
  logic        stall_out;
  logic        pcsrc_out;
  logic [31:0] pc_branch_out;
  logic        valid_out;
  logic [1:0]  crt_wb_out;
  logic [31:0] mem_data_out;
  logic [31:0] alu_result_out;
  logic [4:0]  inst_out;
  logic        misalign_out;
  logic        bus_err_out;

  int n_vec = 0;
  int n_err = 0;

  mem_stage_if dmem ();

  mem_stage #(.TIMEOUT(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .VALID_IN      (valid_in),
    .CRT_MEM_IN    (crt_mem_in),
    .CRT_WB_IN     (crt_wb_in),
    .FUNCT3_IN     (funct3_in),
    .ALU_RESULT_IN (alu_result_in),
    .DATO_B_IN     (dato_b_in),
    .INST_IN       (inst_in),
    .ZERO_IN       (zero_in),
    .PC_NEXT_IN    (pc_next_in),
    .STALL_OUT     (stall_out),
    .PCSRC_OUT     (pcsrc_out),
    .PC_BRANCH_OUT (pc_branch_out),
    .dmem          (dmem),
    .VALID_OUT     (valid_out),
    .CRT_WB_OUT    (crt_wb_out),
    .MEM_DATA_OUT  (mem_data_out),
    .ALU_RESULT_OUT(alu_result_out),
    .INST_OUT      (inst_out),
    .MISALIGN_OUT  (misalign_out),
    .BUS_ERR_OUT   (bus_err_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] mem, input logic [1:0] wb, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] b, input logic [4:0] rd);
    valid_in      = 1'b1;
    crt_mem_in    = mem;
    crt_wb_in     = wb;
    funct3_in     = f3;
    alu_result_in = alu;
    dato_b_in     = b;
    inst_in       = rd;
    tick();
    valid_in   = 1'b0;
    crt_mem_in = 3'b000;
  endtask

  // Load with READY in the first ACCESS cycle: result two edges after issue.
  task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rdata, input logic [31:0] exp);
    issue(3'b001, 2'b11, f3, addr, 32'h0, 5'd7);
    check({tag, "_addr"}, dmem.DMEM_ADDR, {addr[31:2], 2'b00});
    check({tag, "_we"}, {31'd0, dmem.DMEM_WE}, 32'd0);
    dmem.DMEM_READY = 1'b1;
    dmem.DMEM_RDATA = rdata;
    tick();
    dmem.DMEM_READY = 1'b0;
    dmem.DMEM_RDATA = 32'h0;
    check({tag, "_valid"}, {31'd0, valid_out}, 32'd1);
    check({tag, "_data"}, mem_data_out, exp);
    check({tag, "_wb"}, {30'd0, crt_wb_out}, 32'd3);
    tick();
  endtask

  int stall_cnt;

  initial begin
    rst_n = 1'b0;
    valid_in = 1'b0; crt_mem_in = '0; crt_wb_in = '0; funct3_in = '0;
    alu_result_in = '0; dato_b_in = '0; inst_in = '0; zero_in = 1'b0; pc_next_in = '0;
    dmem.DMEM_READY = 1'b0;
    dmem.DMEM_RDATA = '0;
    tick(); tick();

    // Reset state
    check("rst_valid_out", {31'd0, valid_out}, 32'd0);
    check("rst_dmem_valid", {31'd0, dmem.DMEM_VALID}, 32'd0);
    check("rst_stall", {31'd0, stall_out}, 32'd0);
    check("rst_alu_out", alu_result_out, 32'd0);
    check("rst_wstrb", {28'd0, dmem.DMEM_WSTRB}, 32'd0);
    rst_n = 1'b1;
    tick();

    // ADD: one-edge pass-through, no bus request
    issue(3'b000, 2'b01, 3'b000, 32'h0000_1234, 32'h0, 5'd5);
    check("add_valid", {31'd0, valid_out}, 32'd1);
    check("add_alu", alu_result_out, 32'h0000_1234);
    check("add_rd", {27'd0, inst_out}, 32'd5);
    check("add_wb", {30'd0, crt_wb_out}, 32'd1);
    check("add_no_req", {31'd0, dmem.DMEM_VALID}, 32'd0);
    tick();
    check("add_pulse_end", {31'd0, valid_out}, 32'd0);
    check("add_alu_hold", alu_result_out, 32'h0000_1234);

    // SW with three wait cycles; READY lands on the last-wait edge
    issue(3'b010, 2'b00, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 5'd0);
    check("sw_req", {31'd0, dmem.DMEM_VALID}, 32'd1);
    check("sw_we", {31'd0, dmem.DMEM_WE}, 32'd1);
    check("sw_wstrb", {28'd0, dmem.DMEM_WSTRB}, 32'hF);
    check("sw_wdata", dmem.DMEM_WDATA, 32'hDEAD_BEEF);
    stall_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (stall_out) stall_cnt++;
      check("sw_hold_addr", dmem.DMEM_ADDR, 32'h0000_0100);
      tick();
    end
    check("sw_no_early_valid", {31'd0, valid_out}, 32'd0);
    dmem.DMEM_READY = 1'b1;
    if (stall_out) stall_cnt++;
    tick();
    dmem.DMEM_READY = 1'b0;
    check("sw_stall_cycles", stall_cnt, 32'd4);
    check("sw_valid", {31'd0, valid_out}, 32'd1);
    check("sw_buserr", {31'd0, bus_err_out}, 32'd0);
    check("sw_req_drop", {31'd0, dmem.DMEM_VALID}, 32'd0);
    check("sw_stall_drop", {31'd0, stall_out}, 32'd0);
    check("sw_memdata", mem_data_out, 32'd0);
    check("sw_alu", alu_result_out, 32'h0000_0100);
    tick();

    // Sign/zero-extended loads from selected lanes
    run_load("lb", 3'b000, 32'h0000_0203, 32'h8012_3456, 32'hFFFF_FF80);
    check("lb_hold", mem_data_out, 32'hFFFF_FF80);
    run_load("lbu", 3'b100, 32'h0000_0203, 32'h8012_3456, 32'h0000_0080);
    run_load("lh", 3'b001, 32'h0000_0202, 32'h8001_5678, 32'hFFFF_8001);
    run_load("lhu", 3'b101, 32'h0000_0200, 32'h1234_9ABC, 32'h0000_9ABC);
    run_load("lw", 3'b010, 32'h0000_0204, 32'hCAFE_F00D, 32'hCAFE_F00D);

    // Byte and half stores
    issue(3'b010, 2'b00, 3'b000, 32'h0000_0001, 32'h0000_00AB, 5'd0);
    check("sb_wdata", dmem.DMEM_WDATA, 32'hABAB_ABAB);
    check("sb_wstrb", {28'd0, dmem.DMEM_WSTRB}, 32'h2);
    check("sb_addr", dmem.DMEM_ADDR, 32'h0000_0000);
    dmem.DMEM_READY = 1'b1; tick(); dmem.DMEM_READY = 1'b0; tick();
    issue(3'b010, 2'b00, 3'b001, 32'h0000_0002, 32'h0000_CDEF, 5'd0);
    check("sh_wdata", dmem.DMEM_WDATA, 32'hCDEF_CDEF);
    check("sh_wstrb", {28'd0, dmem.DMEM_WSTRB}, 32'hC);
    dmem.DMEM_READY = 1'b1; tick(); dmem.DMEM_READY = 1'b0; tick();

    // Both access bits set: read has priority
    issue(3'b011, 2'b11, 3'b010, 32'h0000_0100, 32'h1111_1111, 5'd3);
    check("rw_prio_we", {31'd0, dmem.DMEM_WE}, 32'd0);
    dmem.DMEM_READY = 1'b1; tick(); dmem.DMEM_READY = 1'b0; tick();

    // Misaligned LW: no request, flagged write-back
    issue(3'b001, 2'b11, 3'b010, 32'h0000_0102, 32'h0, 5'd9);
    check("mis_valid", {31'd0, valid_out}, 32'd1);
    check("mis_flag", {31'd0, misalign_out}, 32'd1);
    check("mis_wb", {30'd0, crt_wb_out}, 32'd0);
    check("mis_no_req", {31'd0, dmem.DMEM_VALID}, 32'd0);
    check("mis_no_stall", {31'd0, stall_out}, 32'd0);
    tick();
    // Misaligned SH (addr[0]=1)
    issue(3'b010, 2'b01, 3'b001, 32'h0000_0003, 32'h0, 5'd9);
    check("mis_sh_flag", {31'd0, misalign_out}, 32'd1);
    tick();

    // Timeout: READY never comes, TIMEOUT=4
    issue(3'b001, 2'b11, 3'b010, 32'h0000_0300, 32'h0, 5'd4);
    for (int i = 0; i < 3; i++) tick();
    check("to_still_stall", {31'd0, stall_out}, 32'd1);
    check("to_no_valid_yet", {31'd0, valid_out}, 32'd0);
    tick();
    check("to_valid", {31'd0, valid_out}, 32'd1);
    check("to_buserr", {31'd0, bus_err_out}, 32'd1);
    check("to_wb", {30'd0, crt_wb_out}, 32'd0);
    check("to_idle", {31'd0, stall_out}, 32'd0);
    check("to_req_drop", {31'd0, dmem.DMEM_VALID}, 32'd0);
    tick();

    // Branch, combinational in IDLE
    valid_in = 1'b1; crt_mem_in = 3'b100; zero_in = 1'b1; pc_next_in = 32'h0000_0040;
    #1;
    check("beq_taken", {31'd0, pcsrc_out}, 32'd1);
    check("beq_target", pc_branch_out, 32'h0000_0040);
    zero_in = 1'b0;
    #1;
    check("beq_not_taken", {31'd0, pcsrc_out}, 32'd0);
    valid_in = 1'b0; crt_mem_in = 3'b000;
    tick();

    // Reset mid-ACCESS: request abandoned, no write-back pulse
    issue(3'b001, 2'b11, 3'b010, 32'h0000_0400, 32'h0, 5'd6);
    valid_in = 1'b1; crt_mem_in = 3'b100; zero_in = 1'b1;
    #1;
    check("branch_in_access", {31'd0, pcsrc_out}, 32'd0);
    valid_in = 1'b0; crt_mem_in = 3'b000; zero_in = 1'b0;
    rst_n = 1'b0;
    tick();
    check("rst_mid_req", {31'd0, dmem.DMEM_VALID}, 32'd0);
    check("rst_mid_valid", {31'd0, valid_out}, 32'd0);
    check("rst_mid_stall", {31'd0, stall_out}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("rst_after_valid", {31'd0, valid_out}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
